// File: rtl/pp_accumulator.sv
// Decodes sign/mantissa/exponent partial products and sums groups of NUM_PP terms.
// Saturating adds are built only when PP_ACC_SAT_EN is defined; otherwise adds wrap and out_sat is 0.
//
// state | meaning
// ACCUM | cnt counting terms of the current group, pipeline advancing
// HOLD  | out_valid & ~out_ready, stage A and stage B frozen
module pp_accumulator #(
   parameter int NUM_PP  = 9,
   parameter int ACC_W   = 32,
   parameter int EXP_MAX = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_pp,
   input  logic [4:0]       in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_err,
   output logic             out_sat
);
   localparam int CNT_W = $clog2(NUM_PP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PP - 1);
   localparam logic [5:0] EXP_LIM = 6'(EXP_MAX);

   logic             stall;
   logic             hidden;
   logic             dec_err;
   logic [ACC_W-1:0] mag;
   logic [ACC_W-1:0] dec_value;
   logic             va;
   logic [ACC_W-1:0] a_value;
   logic             a_err;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             err_sticky;
   logic             grp_step;
   logic             grp_last;
   logic [ACC_W-1:0] sum_raw;
   logic [ACC_W-1:0] sum_next;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign grp_step = va & ~stall;
   assign grp_last = grp_step & (cnt == CNT_LAST);

   always_comb begin
      hidden    = in_pp[3];
      mag       = {{(ACC_W-4){1'b0}}, 1'b1, in_pp[2:0]} << in_exp;
      dec_err   = hidden & ({1'b0, in_exp} > EXP_LIM);
      dec_value = '0;
      if (hidden && !dec_err)
         dec_value = in_pp[4] ? (~mag + 1'b1) : mag;
   end

   // Stage A: while not stalled in_ready is 1, so va simply follows in_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         va      <= 1'b0;
         a_value <= '0;
         a_err   <= 1'b0;
      end else if (!stall) begin
         va      <= in_valid;
         a_value <= dec_value;
         a_err   <= dec_err;
      end
   end

   assign sum_raw = acc + a_value;

`ifdef PP_ACC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic sum_clip;
   logic sat_sticky;

   always_comb begin
      sum_clip = (acc[ACC_W-1] == a_value[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
      sum_next = sum_raw;
      if (sum_clip)
         sum_next = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sat_sticky <= 1'b0;
         out_sat    <= 1'b0;
      end else if (grp_last) begin
         out_sat    <= sat_sticky | sum_clip;
         sat_sticky <= 1'b0;
      end else if (grp_step) begin
         sat_sticky <= sat_sticky | sum_clip;
      end
   end
`else
   assign sum_next = sum_raw;
   assign out_sat  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc        <= '0;
         cnt        <= '0;
         err_sticky <= 1'b0;
         out_valid  <= 1'b0;
         out_sum    <= '0;
         out_err    <= 1'b0;
      end else begin
         if (grp_last) begin
            out_sum    <= sum_next;
            out_err    <= err_sticky | a_err;
            acc        <= '0;
            cnt        <= '0;
            err_sticky <= 1'b0;
         end else if (grp_step) begin
            acc        <= sum_next;
            cnt        <= cnt + 1'b1;
            err_sticky <= err_sticky | a_err;
         end
         // A completing group wins over the consumer draining the previous one.
         if (grp_last)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: default 32-bit instance plus a 16-bit instance for wrap/saturation.
module tb_pp_accumulator;
   localparam logic [4:0] P52  = 5'b01101;
   localparam logic [4:0] N52  = 5'b11101;
   localparam logic [4:0] P8   = 5'b01000;
   localparam logic [4:0] BIG  = 5'b01111;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_pp;
   logic [4:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_err;
   logic        out_sat;

   logic        n_in_valid;
   logic        n_in_ready;
   logic [4:0]  n_in_pp;
   logic [4:0]  n_in_exp;
   logic        n_out_valid;
   logic        n_out_ready;
   logic [15:0] n_out_sum;
   logic        n_out_err;
   logic        n_out_sat;

   int checks;
   int passes;

   pp_accumulator dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp), .in_exp(in_exp),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_err(out_err), .out_sat(out_sat)
   );

   pp_accumulator #(.NUM_PP(9), .ACC_W(16), .EXP_MAX(22)) dut_n (
      .clk(clk), .rst(rst),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_pp(n_in_pp), .in_exp(n_in_exp),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_sum(n_out_sum),
      .out_err(n_out_err), .out_sat(n_out_sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input logic [4:0] pp, input logic [4:0] e);
      in_valid = 1'b1;
      in_pp    = pp;
      in_exp   = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int i;
      i = 0;
      while (!out_valid && i < 20) begin
         @(posedge clk);
         #1;
         i++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passes++;
      checks++; if (out_sum !== 32'd0) $display("FAIL reset_sum: got %0d expected 0", out_sum); else passes++;
      checks++; if (out_err !== 1'b0 || out_sat !== 1'b0) $display("FAIL reset_flags: got err=%b sat=%b expected 0 0", out_err, out_sat); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else passes++;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 9; k++) push(P52, 5'd2);
      checks++; if (out_valid !== 1'b0) $display("FAIL basic_early: got out_valid=%b expected 0", out_valid); else passes++;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency: got out_valid=%b expected 1", out_valid); else passes++;
      checks++; if (out_sum !== 32'd468) $display("FAIL basic_sum: got %0d expected 468", out_sum); else passes++;
      checks++; if (out_err !== 1'b0 || out_sat !== 1'b0) $display("FAIL basic_flags: got err=%b sat=%b expected 0 0", out_err, out_sat); else passes++;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL basic_pulse: got out_valid=%b expected 0", out_valid); else passes++;
   endtask

   task automatic test_signs();
      bit ok;
      for (int k = 0; k < 9; k++) push((k % 2 == 0) ? P52 : N52, 5'd2);
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd52) $display("FAIL signs_sum: got valid=%b sum=%0d expected 52", ok, $signed(out_sum)); else passes++;
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) push(5'b00000, 5'd7);
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd0) $display("FAIL zero_sum: got valid=%b sum=%0d expected 0", ok, $signed(out_sum)); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      bit ok;
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) push(P52, 5'd2);
      wait_out(ok);
      checks++; if (!ok) $display("FAIL stall_timeout: got no out_valid expected 1"); else passes++;
      in_valid = 1'b1;
      in_pp    = P8;
      in_exp   = 5'd0;
      for (int c = 0; c < 5; c++) begin
         checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid: cycle %0d got %b expected 1", c, out_valid); else passes++;
         checks++; if (out_sum !== 32'd468) $display("FAIL stall_sum: cycle %0d got %0d expected 468", c, out_sum); else passes++;
         checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready: cycle %0d got %b expected 0", c, in_ready); else passes++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) push(P8, 5'd0);
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd72) $display("FAIL stall_next_sum: got valid=%b sum=%0d expected 72", ok, out_sum); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_exp_err();
      bit ok;
      for (int k = 0; k < 9; k++) begin
         if (k == 4) push(5'b01000, 5'd23);
         else push(P52, 5'd2);
      end
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd416) $display("FAIL err_sum: got valid=%b sum=%0d expected 416", ok, out_sum); else passes++;
      checks++; if (out_err !== 1'b1) $display("FAIL err_flag: got %b expected 1", out_err); else passes++;
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) push(P52, 5'd2);
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd468) $display("FAIL err_clean_sum: got valid=%b sum=%0d expected 468", ok, out_sum); else passes++;
      checks++; if (out_err !== 1'b0) $display("FAIL err_clean_flag: got %b expected 0", out_err); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int          n_out;
      logic [31:0] sums [4];
      int          cyc  [4];
      n_out = 0;
      fork
         begin
            for (int k = 0; k < 18; k++) push((k < 9) ? P52 : N52, 5'd2);
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(posedge clk); #1;
               if (out_valid && n_out < 4) begin
                  sums[n_out] = out_sum;
                  cyc[n_out]  = c;
                  n_out++;
               end
            end
         end
      join
      checks++; if (n_out !== 2) $display("FAIL b2b_count: got %0d pulses expected 2", n_out); else passes++;
      if (n_out >= 2) begin
         checks++; if (sums[0] !== 32'd468) $display("FAIL b2b_sum0: got %0d expected 468", sums[0]); else passes++;
         checks++; if ($signed(sums[1]) !== -468) $display("FAIL b2b_sum1: got %0d expected -468", $signed(sums[1])); else passes++;
         checks++; if (cyc[1] - cyc[0] !== 9) $display("FAIL b2b_gap: got %0d cycles expected 9", cyc[1] - cyc[0]); else passes++;
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int k = 0; k < 4; k++) push(P8, 5'd3);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid_state: got valid=%b ready=%b expected 0 1", out_valid, in_ready); else passes++;
      for (int k = 0; k < 9; k++) push(P52, 5'd2);
      wait_out(ok);
      checks++; if (!ok || out_sum !== 32'd468) $display("FAIL rst_mid_sum: got valid=%b sum=%0d expected 468", ok, out_sum); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_narrow();
      int i;
      for (int k = 0; k < 9; k++) begin
         n_in_valid = 1'b1;
         n_in_pp    = BIG;
         n_in_exp   = 5'd10;
         @(posedge clk); #1;
      end
      n_in_valid = 1'b0;
      i = 0;
      while (!n_out_valid && i < 20) begin
         @(posedge clk); #1;
         i++;
      end
`ifdef PP_ACC_SAT_EN
      checks++; if (!n_out_valid || n_out_sum !== 16'd32767) $display("FAIL narrow_sum: got valid=%b sum=%0d expected 32767", n_out_valid, n_out_sum); else passes++;
      checks++; if (n_out_sat !== 1'b1) $display("FAIL narrow_sat: got %b expected 1", n_out_sat); else passes++;
`else
      checks++; if (!n_out_valid || n_out_sum !== 16'd7168) $display("FAIL narrow_sum: got valid=%b sum=%0d expected 7168", n_out_valid, n_out_sum); else passes++;
      checks++; if (n_out_sat !== 1'b0) $display("FAIL narrow_sat: got %b expected 0", n_out_sat); else passes++;
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      checks      = 0;
      passes      = 0;
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_pp       = 5'b0;
      in_exp      = 5'b0;
      out_ready   = 1'b1;
      n_in_valid  = 1'b0;
      n_in_pp     = 5'b0;
      n_in_exp    = 5'b0;
      n_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_signs();
      test_stall();
      test_exp_err();
      test_back_to_back();
      test_reset_mid();
      test_narrow();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
